lives_hud_renderer: RTL and testbench
=====================================

# lives_hud_renderer

Renders the remaining-lives HUD strip: a row of 24x24 frog icons near the bottom of the screen. Sits between the VGA scan position and the lives sprite ROM. Issues ROM read addresses from DrawX/DrawY and consumes the ROM's registered 4-bit palette index one cycle later. Also owns the lives counter, the lost-life blink animation and the game-over flag; its colour output feeds the colour mapper.

## Interface
- X0, 16: left pixel column of icon 0
- Y0, 452: top pixel row of the icon strip
- MAX_LIVES, 5: icon slots drawn (≤7)
- START_LIVES, 3: lives after reset/new_game (1..MAX_LIVES)
- BLINK_FRAMES, 64: frames of blink after a life is lost (≥1, ≤256)

Ports:
- Clk  in  1  system clock; one clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle pulse per video frame
- lose_life  in  1  one-cycle pulse: frog died
- new_game  in  1  one-cycle pulse: restore lives
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- rom_addr  out  10  lives sprite ROM read address (ROM registers output, 1-cycle latency)
- rom_data  in  4  ROM palette index, valid the cycle after rom_addr
- lives  out  3  current lives count
- game_over  out  1  high while state is OVER
- hud_on  out  1  HUD pixel opaque at the DrawX/DrawY of previous cycle
- hud_color_idx  out  4  palette index; 0 when hud_on=0

## Operation
- Geometry: dx=DrawX−X0, dy=DrawY−Y0; slot k=dx>>5, lx=dx[4:0], ly=dy. Icon pitch 32 px, icon 24 px, gap 8 px.
- in_region: DrawX≥X0, DrawY≥Y0, dy<24, k<MAX_LIVES, lx<24.
- rom_addr = ly*24+lx (ly*16+ly*8+lx, max 575) when in_region, else 0. Combinational.
- Slot visible: k<lives, or (state BLINK and k==lives and blink_cnt[3]==1).
- hit_q register ← in_region && slot visible, every cycle.
- hud_on = hit_q && rom_data≠0; index 0 is transparent.
- hud_color_idx = hud_on ? rom_data : 0.
- Lives/FSM states: IDLE, BLINK, OVER. Reset → IDLE, lives=START_LIVES, blink_cnt=0, hit_q=0.
- new_game, any state → IDLE, lives=START_LIVES, blink_cnt=0. Has priority over lose_life in the same cycle.
- lose_life with lives>0 → lives−1, blink_cnt=0, state BLINK. This also applies when already in BLINK: the blink restarts on the newly lost slot.
- lose_life with lives==0 is ignored.
- In BLINK, each frame_start increments blink_cnt. At the frame_start where blink_cnt==BLINK_FRAMES−1, leave BLINK: go to OVER if lives==0, else IDLE.
- OVER is left only by new_game or Reset.

## Timing
- rom_addr is combinational from DrawX/DrawY in cycle n.
- hud_on/hud_color_idx for that pixel are valid in cycle n+1. Total latency is 1 cycle; the downstream mapper delays its DrawX/DrawY match by one cycle.
- lives, state and game_over update on the edge where the lose_life/new_game pulse is sampled, and are visible the next cycle.
- lose_life and frame_start in the same cycle: the decrement and blink restart win, so blink_cnt=0.
- Reset mid-BLINK: next cycle IDLE, lives=START_LIVES, hud_on=0, hud_color_idx=0.
- Reset values of outputs: lives=START_LIVES, game_over=0, hud_on=0, hud_color_idx=0, rom_addr=f(DrawX,DrawY).

## Configuration
- LIVES_BLINK_EN defined: BLINK state and blink_cnt exist as described above.
- LIVES_BLINK_EN undefined: no BLINK state and no counter.
  - lose_life → IDLE when the new lives>0, else OVER.
  - The lost icon disappears on the next cycle.
  - frame_start is unused.

## Test plan
- Reset, lives=3; DrawX=X0+1, DrawY=Y0 → rom_addr=1. Next cycle with rom_data=5 → hud_on=1, hud_color_idx=5.
- rom_data=0 inside icon → hud_on=0, index 0. DrawX=X0+24 (gap) → rom_addr=0, hud_on=0 next cycle. DrawX=X0+96 (slot 3, lives=3) → hud_on=0. DrawX=X0+23, DrawY=Y0+23 → rom_addr=575.
- lose_life → lives=2, BLINK. Slot 2 is hidden for frame_starts 0–7 and visible for 8–15. After 64 frame_start pulses → IDLE; slot 2 then stays hidden.
- Three lose_life pulses, then 64 frames → lives=0, game_over=1. A fourth lose_life → lives stays 0. new_game → lives=3, game_over=0.
- new_game and lose_life in the same cycle with lives=2 → lives=3, IDLE.
- Reset asserted in BLINK at blink_cnt=20 → IDLE, lives=3, hud_on=0, game_over=0. Without LIVES_BLINK_EN: lose_life from lives=1 → game_over=1 on the next cycle.

Source files
------------

// File: rtl/lives_hud_renderer.sv
// Lives counter, lost-life blink animation and renderer for the row of frog
// icons in the HUD. Define LIVES_BLINK_EN to build the BLINK state and counter.
module lives_hud_renderer #(
  parameter int X0           = 16,
  parameter int Y0           = 452,
  parameter int MAX_LIVES    = 5,
  parameter int START_LIVES  = 3,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_start,
  input  logic       lose_life,
  input  logic       new_game,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] rom_addr,
  input  logic [3:0] rom_data,
  output logic [2:0] lives,
  output logic       game_over,
  output logic       hud_on,
  output logic [3:0] hud_color_idx
);

  localparam logic [9:0] X0_V       = 10'(X0);
  localparam logic [9:0] Y0_V       = 10'(Y0);
  localparam logic [4:0] MAX_SLOT   = 5'(MAX_LIVES);
  localparam logic [2:0] START_V    = 3'(START_LIVES);

`ifdef LIVES_BLINK_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);
  typedef enum logic [1:0] {IDLE, BLINK, OVER} state_t;
`else
  typedef enum logic {IDLE, OVER} state_t;
`endif

  state_t     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic       hit_q, hit_d;
  logic [9:0] dx, dy;
  logic [4:0] slot, lx, ly;
  logic       in_region, slot_vis;

`ifdef LIVES_BLINK_EN
  logic [7:0] blink_cnt_q, blink_cnt_d;
`else
  logic [8:0] unused_cfg;
  assign unused_cfg = {frame_start, 8'(BLINK_FRAMES - 1)};
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      lives_q <= START_V;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lives_q <= lives_d;
      hit_q   <= hit_d;
    end
  end

`ifdef LIVES_BLINK_EN
  always_ff @(posedge Clk) begin
    if (Reset) blink_cnt_q <= '0;
    else       blink_cnt_q <= blink_cnt_d;
  end
`endif

  // new_game outranks lose_life; a loss restarts the blink on the new slot
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
`ifdef LIVES_BLINK_EN
    blink_cnt_d = blink_cnt_q;
    if (new_game) begin
      state_d     = IDLE;
      lives_d     = START_V;
      blink_cnt_d = '0;
    end else if (lose_life && lives_q != 3'd0) begin
      state_d     = BLINK;
      lives_d     = lives_q - 3'd1;
      blink_cnt_d = '0;
    end else if (state_q == BLINK && frame_start) begin
      if (blink_cnt_q == BLINK_LAST) begin
        state_d     = (lives_q == 3'd0) ? OVER : IDLE;
        blink_cnt_d = '0;
      end else begin
        blink_cnt_d = blink_cnt_q + 8'd1;
      end
    end
`else
    if (new_game) begin
      state_d = IDLE;
      lives_d = START_V;
    end else if (lose_life && lives_q != 3'd0) begin
      lives_d = lives_q - 3'd1;
      state_d = (lives_q == 3'd1) ? OVER : IDLE;
    end
`endif
  end

  always_comb begin
    dx        = DrawX - X0_V;
    dy        = DrawY - Y0_V;
    slot      = dx[9:5];
    lx        = dx[4:0];
    ly        = dy[4:0];
    in_region = (DrawX >= X0_V) && (DrawY >= Y0_V) && (dy < 10'd24) &&
                (slot < MAX_SLOT) && (lx < 5'd24);
    slot_vis  = slot < {2'b00, lives_q};
`ifdef LIVES_BLINK_EN
    if (state_q == BLINK && slot == {2'b00, lives_q} && blink_cnt_q[3])
      slot_vis = 1'b1;
`endif
    rom_addr      = in_region ? ({1'b0, ly, 4'b0000} + {2'b00, ly, 3'b000} + {5'b00000, lx})
                              : 10'd0;
    hit_d         = in_region && slot_vis;
    hud_on        = hit_q && (rom_data != 4'd0);
    hud_color_idx = hud_on ? rom_data : 4'd0;
    lives         = lives_q;
    game_over     = (state_q == OVER);
  end

endmodule

// File: tb/tb_lives_hud_renderer.sv
// Self-checking bench for lives_hud_renderer: directed steps followed by random
// traffic, checked against a frame/slot-level reference model.
module tb_lives_hud_renderer;

  localparam int X0           = 16;
  localparam int Y0           = 452;
  localparam int MAX_LIVES    = 5;
  localparam int START_LIVES  = 3;
  localparam int BLINK_FRAMES = 64;

  logic       Clk = 1'b0;
  logic       Reset, frame_start, lose_life, new_game;
  logic [9:0] DrawX, DrawY, rom_addr;
  logic [3:0] rom_data, hud_color_idx;
  logic [2:0] lives;
  logic       game_over, hud_on;

  int test_count = 0;
  int fail_count = 0;

  int m_lives    = 0;
  bit m_over     = 0;
  bit m_blinking = 0;
  int m_frames   = 0;
  bit exp_hit    = 0;

  lives_hud_renderer #(
    .X0(X0), .Y0(Y0), .MAX_LIVES(MAX_LIVES),
    .START_LIVES(START_LIVES), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .lose_life(lose_life),
    .new_game(new_game), .DrawX(DrawX), .DrawY(DrawY), .rom_addr(rom_addr),
    .rom_data(rom_data), .lives(lives), .game_over(game_over), .hud_on(hud_on),
    .hud_color_idx(hud_color_idx)
  );

  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [31:0] observed, input int expected);
    test_count++;
    assert (observed === expected) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Icon geometry from pitch/width arithmetic
  function automatic void pixelModel(input int x, input int y, output bit region,
                                     output int addr, output int slot);
    int dx, dy, lx;
    region = 0; addr = 0; slot = 0;
    if (x >= X0 && y >= Y0) begin
      dx = x - X0; dy = y - Y0;
      slot = dx / 32; lx = dx % 32;
      if (dy < 24 && slot < MAX_LIVES && lx < 24) begin
        region = 1;
        addr   = dy * 24 + lx;
      end
    end
  endfunction

  function automatic bit slotShown(input int slot);
    return (slot < m_lives) ||
           (m_blinking && slot == m_lives && ((m_frames / 8) % 2 == 1));
  endfunction

  task automatic modelUpdate(input bit fs, input bit ll, input bit ng, input bit rst);
    if (rst || ng) begin
      m_lives = START_LIVES; m_over = 0; m_blinking = 0; m_frames = 0;
    end else if (ll && m_lives > 0) begin
      m_lives--;
`ifdef LIVES_BLINK_EN
      m_blinking = 1; m_frames = 0;
`else
      m_over = (m_lives == 0);
`endif
    end else if (m_blinking && fs) begin
      m_frames++;
      if (m_frames == BLINK_FRAMES) begin
        m_blinking = 0; m_frames = 0; m_over = (m_lives == 0);
      end
    end
  endtask

  task automatic checkOutput(input int rd);
    bit on;
    on = exp_hit && (rd != 0);
    checkVal("hud_on", 32'(hud_on), int'(on));
    checkVal("hud_color_idx", 32'(hud_color_idx), on ? rd : 0);
    checkVal("lives", 32'(lives), m_lives);
    checkVal("game_over", 32'(game_over), int'(m_over));
  endtask

  // One cycle: present pixel and pulses, then play the ROM's registered reply
  task automatic applyStimulus(input int x, input int y, input int rd, input bit fs,
                               input bit ll, input bit ng, input bit rst);
    bit region;
    int addr, slot;
    DrawX = 10'(x); DrawY = 10'(y);
    frame_start = fs; lose_life = ll; new_game = ng; Reset = rst;
    #1;
    pixelModel(x, y, region, addr, slot);
    checkVal("rom_addr", 32'(rom_addr), addr);
    exp_hit = region && slotShown(slot);
    @(posedge Clk);
    modelUpdate(fs, ll, ng, rst);
    if (rst) exp_hit = 0;
    #1;
    frame_start = 0; lose_life = 0; new_game = 0; Reset = 0;
    rom_data = 4'(rd);
    #1;
    checkOutput(rd);
  endtask

  initial begin
    Reset = 1; frame_start = 0; lose_life = 0; new_game = 0;
    DrawX = 0; DrawY = 0; rom_data = 0;

    applyStimulus(X0 + 1, Y0, 0, 0, 0, 0, 1);
    applyStimulus(X0 + 1, Y0, 0, 0, 0, 0, 1);
    applyStimulus(X0 + 1, Y0, 5, 0, 0, 0, 0);
    applyStimulus(X0 + 1, Y0, 0, 0, 0, 0, 0);
    applyStimulus(X0 + 24, Y0, 9, 0, 0, 0, 0);
    applyStimulus(X0 + 96, Y0, 9, 0, 0, 0, 0);
    applyStimulus(X0 + 23, Y0 + 23, 9, 0, 0, 0, 0);
    applyStimulus(X0 + 64 + 23, Y0 + 24, 9, 0, 0, 0, 0);
    applyStimulus(X0 + 160, Y0 + 5, 9, 0, 0, 0, 0);

    // lose one life and watch slot 2 through the whole blink
    applyStimulus(X0 + 66, Y0 + 3, 6, 0, 1, 0, 0);
    for (int i = 0; i < BLINK_FRAMES + 3; i++)
      applyStimulus(X0 + 66, Y0 + 3, 6, 1, 0, 0, 0);
    applyStimulus(X0 + 66, Y0 + 3, 6, 0, 0, 0, 0);

    // run out of lives
    applyStimulus(X0 + 2, Y0 + 2, 3, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(X0 + 2, Y0 + 2, 3, 0, 1, 0, 0);
    for (int i = 0; i < BLINK_FRAMES + 2; i++)
      applyStimulus(X0 + 2, Y0 + 2, 3, 1, 0, 0, 0);
    applyStimulus(X0 + 2, Y0 + 2, 3, 0, 1, 0, 0);
    applyStimulus(X0 + 2, Y0 + 2, 3, 0, 0, 1, 0);
    applyStimulus(X0 + 2, Y0 + 2, 3, 0, 0, 0, 0);

    // new_game beats lose_life in the same cycle
    applyStimulus(X0 + 34, Y0 + 1, 4, 0, 1, 0, 0);
    applyStimulus(X0 + 34, Y0 + 1, 4, 0, 1, 1, 0);
    applyStimulus(X0 + 66, Y0 + 1, 4, 0, 0, 0, 0);

    // lose_life and frame_start together, then reset mid-blink
    applyStimulus(X0 + 5, Y0 + 5, 2, 1, 1, 0, 0);
    for (int i = 0; i < 20; i++)
      applyStimulus(X0 + 5, Y0 + 5, 2, 1, 0, 0, 0);
    applyStimulus(X0 + 5, Y0 + 5, 2, 0, 0, 0, 1);
    applyStimulus(X0 + 5, Y0 + 5, 2, 0, 0, 0, 0);

    // last life lost
    applyStimulus(X0 + 5, Y0 + 5, 2, 0, 1, 0, 0);
    applyStimulus(X0 + 5, Y0 + 5, 2, 0, 1, 0, 0);
    applyStimulus(X0 + 5, Y0 + 5, 2, 0, 1, 0, 0);
    applyStimulus(X0 + 5, Y0 + 5, 2, 0, 0, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 200), $urandom_range(440, 482),
                    $urandom_range(0, 15),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 29) == 0),
                    ($urandom_range(0, 119) == 0),
                    ($urandom_range(0, 399) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
